gpmc_sram_burst: RTL



---
 rtl/gpmc_sram_burst_if.sv | 33 +++
 rtl/gpmc_sram_burst.sv | 136 +++++++++++++
 2 files changed

// File: rtl/gpmc_sram_burst_if.sv
// gpmc_sram_burst_if
// Bundles the GPMC pad-side signals of one chip-select window.
//   GPMC_AD_IN     host -> slave  muxed address (ADV phase) / write data
//   GPMC_DATA_OUT  slave -> host  read data
//   GPMC_DATA_OE   slave -> host  high = pad ring drives GPMC_DATA_OUT onto AD
//   GPMC_CS/ADV/OE/WE/BE0/BE1  host -> slave, all active-low
//   GPMC_WAIT      slave -> host  read-data-valid flow control
// Flow control: GPMC has no valid/ready pair. The host owns every edge.
// A read word counts as transferred on each edge where OE is low and WAIT is low.
// While WAIT is high the host keeps OE low and the slave keeps filling its pipe.
// A write word transfers on every edge where WE is low; it is never stalled.
interface gpmc_sram_burst_if;
  logic [15:0] GPMC_AD_IN;
  logic [15:0] GPMC_DATA_OUT;
  logic        GPMC_DATA_OE;
  logic        GPMC_CS;
  logic        GPMC_ADV;
  logic        GPMC_OE;
  logic        GPMC_WE;
  logic        GPMC_BE0;
  logic        GPMC_BE1;
  logic        GPMC_WAIT;

  modport master (
    output GPMC_AD_IN, GPMC_CS, GPMC_ADV, GPMC_OE, GPMC_WE, GPMC_BE0, GPMC_BE1,
    input  GPMC_DATA_OUT, GPMC_DATA_OE, GPMC_WAIT
  );

  modport slave (
    input  GPMC_AD_IN, GPMC_CS, GPMC_ADV, GPMC_OE, GPMC_WE, GPMC_BE0, GPMC_BE1,
    output GPMC_DATA_OUT, GPMC_DATA_OE, GPMC_WAIT
  );
endinterface

// File: rtl/gpmc_sram_burst.sv
// gpmc_sram_burst
// Synchronous GPMC slave that exposes a 16-bit dual-port RAM in the
// processor's chip-select window. It supports single and burst accesses with
// byte enables. Reads have a fixed latency, and WAIT tells the host when data
// is valid. The fabric side has a registered, read-first read port.
// Ports:
//   GPMC_CLK   sole clock, rising edge
//   RESET      synchronous, active-high
//   bus        GPMC pad signals (slave modport)
//   PROTO_ERR  sticky: WE and OE were low together during an access
//   USR_ADDR   fabric read address
//   USR_DOUT   fabric read data, one edge after USR_ADDR
//   STATE_DBG  current FSM state (0 IDLE, 1 ACCESS, 2 ERROR)
module gpmc_sram_burst #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 3,
  parameter int BURST_LEN  = 8,
  parameter bit WRAP_BURST = 1'b0
) (
  input  logic                  GPMC_CLK,
  input  logic                  RESET,
  gpmc_sram_burst_if.slave      bus,
  output logic                  PROTO_ERR,
  input  logic [ADDR_WIDTH-1:0] USR_ADDR,
  output logic [15:0]           USR_DOUT,
  output logic [1:0]            STATE_DBG
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WRAP_MASK = ADDR_WIDTH'(BURST_LEN - 1);

  logic [15:0]           mem [0:(1 << ADDR_WIDTH) - 1];
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           pipe_data_q [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [15:0]           data_out_q;
  logic                  data_oe_q;
  logic                  wait_q;
  logic                  proto_err_q;
  logic [15:0]           usr_dout_q;

  logic acc_cycle;
  logic wr_en;

  // With wrapping, only the low log2(BURST_LEN) bits count. The upper bits
  // stay fixed, so the burst stays inside its aligned block.
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] lin;
    lin = a + ADDR_WIDTH'(1);
    if (WRAP_BURST) return (a & ~WRAP_MASK) | (lin & WRAP_MASK);
    return lin;
  endfunction

  // A data-phase edge: inside an access, selected, and not an address phase.
  assign acc_cycle = (state_q == S_ACCESS) && !bus.GPMC_CS && bus.GPMC_ADV;
  // RESET blocks the write so that a reset edge never changes the RAM.
  assign wr_en     = acc_cycle && !bus.GPMC_WE && bus.GPMC_OE && !RESET;

  // The RAM array and the read pipeline data have no reset. Validity is
  // tracked in pipe_vld_q, so stale data is never presented to the host.
  always_ff @(posedge GPMC_CLK) begin
    if (wr_en) begin
      if (!bus.GPMC_BE0) mem[addr_q][7:0]  <= bus.GPMC_AD_IN[7:0];
      if (!bus.GPMC_BE1) mem[addr_q][15:8] <= bus.GPMC_AD_IN[15:8];
    end
    pipe_data_q[0] <= mem[addr_q];
    for (int i = 1; i < RD_LATENCY; i++) pipe_data_q[i] <= pipe_data_q[i-1];
  end

  always_ff @(posedge GPMC_CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pipe_vld_q  <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      wait_q      <= 1'b0;
      proto_err_q <= 1'b0;
      usr_dout_q  <= '0;
    end else begin
      // Read-first: a GPMC write on this same edge is only seen one edge later.
      usr_dout_q <= mem[USR_ADDR];
      // By default the read pipe is flushed and the bus is released.
      // Only an ongoing read keeps them alive.
      pipe_vld_q <= '0;
      data_oe_q  <= 1'b0;
      wait_q     <= 1'b0;
      if (bus.GPMC_CS) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!bus.GPMC_ADV) begin
              addr_q  <= bus.GPMC_AD_IN[ADDR_WIDTH-1:0];
              state_q <= S_ACCESS;
            end
          end
          S_ACCESS: begin
            if (!bus.GPMC_ADV) begin
              addr_q <= bus.GPMC_AD_IN[ADDR_WIDTH-1:0];
            end else if (!bus.GPMC_WE && !bus.GPMC_OE) begin
              proto_err_q <= 1'b1;
              state_q     <= S_ERROR;
            end else if (!bus.GPMC_WE) begin
              addr_q <= addr_inc(addr_q);
            end else if (!bus.GPMC_OE) begin
              // Issue a read of addr_q into stage 0. The last stage moves to
              // DATA_OUT, so a word appears RD_LATENCY edges after its issue.
              addr_q     <= addr_inc(addr_q);
              pipe_vld_q <= {pipe_vld_q[RD_LATENCY-2:0], 1'b1};
              data_oe_q  <= 1'b1;
              wait_q     <= !pipe_vld_q[RD_LATENCY-1];
              if (pipe_vld_q[RD_LATENCY-1]) data_out_q <= pipe_data_q[RD_LATENCY-1];
            end
          end
          S_ERROR: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.GPMC_DATA_OUT = data_out_q;
  assign bus.GPMC_DATA_OE  = data_oe_q;
  assign bus.GPMC_WAIT     = wait_q;
  assign PROTO_ERR         = proto_err_q;
  assign USR_DOUT          = usr_dout_q;
  assign STATE_DBG         = state_q;

endmodule
